// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM driving all datapath strobes and selects.
// Optional build macro MIPS_MC_TIMEOUT_EN adds a memory wait timeout that parks the FSM in ERROR.
module mips_mc_controller #(
    parameter int ALU_CTRL_W     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  no_ext,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            pc_src,
    output logic                  pc_write,
    output logic                  illegal_op,
    output logic                  bus_error,
    output logic [3:0]            state_out
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REX    = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] IEX    = 4'd9;
    localparam logic [3:0] IWB    = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] JR     = 4'd12;
    localparam logic [3:0] ERROR  = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_JR     = 6'b001000;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = ALU_CTRL_W'(4'b1100);

    logic [3:0]            state, nxt, dec_nxt;
    logic                  dec_bad, rex_ok, imm_zext, timeout, waiting;
    logic [ALU_CTRL_W-1:0] rex_alu, imm_alu;

    assign waiting   = state == FETCH || state == MEMRD || state == MEMWR;
    assign state_out = state;

`ifdef MIPS_MC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    assign timeout = waiting && !mem_ready && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // consecutive not-ready cycles in the current wait state; any state change restarts it
    always_ff @(posedge clk or posedge reset)
        if (reset) wait_cnt <= '0;
        else if (nxt != state) wait_cnt <= '0;
        else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
`else
    localparam bit TO_EN = 1'b0;
    assign timeout = 1'b0;
`endif

    // instruction field decode: dispatch target, R-type and immediate ALU ops
    always_comb begin
        dec_nxt = FETCH;
        dec_bad = 1'b0;
        case (op)
            OP_LW, OP_SW:                      dec_nxt = MEMADR;
            OP_RTYPE:                          dec_nxt = funct == F_JR ? JR : REX;
            OP_BEQ, OP_BNE:                    dec_nxt = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: dec_nxt = IEX;
            OP_J, OP_JAL:                      dec_nxt = JUMP;
            default:                           dec_bad = 1'b1;
        endcase
        rex_ok  = 1'b1;
        rex_alu = ALU_AND;
        case (funct)
            6'b100000: rex_alu = ALU_ADD;
            6'b100010: rex_alu = ALU_SUB;
            6'b100100: rex_alu = ALU_AND;
            6'b100101: rex_alu = ALU_OR;
            6'b101010: rex_alu = ALU_SLT;
            6'b100111: rex_alu = ALU_NOR;
            default:   rex_ok  = 1'b0;
        endcase
        imm_alu  = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
        imm_zext = op == OP_ANDI || op == OP_ORI;
    end

    // next-state logic; the timeout overrides any wait state
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: nxt = dec_nxt;
            MEMADR: nxt = op == OP_SW ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            REX:    nxt = rex_ok ? ALUWB : FETCH;
            IEX:    nxt = IWB;
            ERROR:  nxt = TO_EN ? ERROR : FETCH;
            default: nxt = FETCH;
        endcase
        if (timeout) nxt = ERROR;
    end

    // state register, asynchronously returned to FETCH
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else state <= nxt;

    // Moore output decode; reset forces every output low
    always_comb begin
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        no_ext      = 1'b0;
        alu_control = ALU_AND;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                end
                DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                    illegal_op  = dec_bad;
                end
                MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                REX: begin
                    alu_src_a   = 1'b1;
                    alu_control = rex_alu;
                    illegal_op  = !rex_ok;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_src      = 2'b01;
                    pc_write    = (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
                end
                IEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = imm_alu;
                    no_ext      = imm_zext;
                end
                IWB: begin
                    reg_write = 1'b1;
                    no_ext    = imm_zext;
                end
                JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    reg_write  = op == OP_JAL;
                    reg_dst    = op == OP_JAL ? 2'b10 : 2'b00;
                    mem_to_reg = op == OP_JAL ? 2'b10 : 2'b00;
                end
                JR: begin
                    pc_src   = 2'b11;
                    pc_write = 1'b1;
                end
                ERROR: bus_error = TO_EN;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: vector table, directed reset/timeout sequences and a randomized path-model check.
module tb_mips_mc_controller;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010, J = 6'b000010, JAL = 6'b000011;

    // strobes {iord, mem_read, mem_write, ir_write, reg_write, pc_write, illegal_op}
    localparam logic [6:0] S_F1 = 7'b0101010, S_F0 = 7'b0100000, S_NO = 7'b0000000, S_ILL = 7'b0000001;
    localparam logic [6:0] S_RD = 7'b1100000, S_WR = 7'b1010000, S_WB = 7'b0000100, S_PW = 7'b0000010, S_JAL = 7'b0000110;
    // selects {reg_dst, mem_to_reg, alu_src_a, alu_src_b, no_ext, alu_control, pc_src}
    localparam logic [13:0] X_FETCH = 14'b00_00_0_01_0_0010_00, X_DEC = 14'b00_00_0_11_0_0010_00;
    localparam logic [13:0] X_MADR = 14'b00_00_1_10_0_0010_00, X_NO = 14'b0, X_MEMWB = 14'b00_01_0_00_0_0000_00;
    localparam logic [13:0] X_ALUWB = 14'b01_00_0_00_0_0000_00, X_BR = 14'b00_00_1_00_0_0110_01;
    localparam logic [13:0] X_J = 14'b00_00_0_00_0_0000_10, X_JAL = 14'b10_10_0_00_0_0000_10, X_JR = 14'b00_00_0_00_0_0000_11;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = 6'b0, funct = 6'b0;
    logic iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, no_ext, pc_write, illegal_op, bus_error;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [3:0] alu_control, state_out;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .no_ext(no_ext), .alu_control(alu_control), .pc_src(pc_src),
        .pc_write(pc_write), .illegal_op(illegal_op), .bus_error(bus_error), .state_out(state_out)
    );

    logic [6:0] s_act;
    logic [13:0] x_act;
    logic [25:0] all_act;
    assign s_act = {iord, mem_read, mem_write, ir_write, reg_write, pc_write, illegal_op};
    assign x_act = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, no_ext, alu_control, pc_src};
    assign all_act = {bus_error, state_out, s_act, x_act};

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic zero;
        logic mr;
        logic [3:0] st;
        logic [6:0] s;
        logic [13:0] x;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [13:0] rexx(input logic [3:0] alu);
        return {2'b00, 2'b00, 1'b1, 2'b00, 1'b0, alu, 2'b00};
    endfunction
    function automatic logic [13:0] iexx(input logic ne, input logic [3:0] alu);
        return {2'b00, 2'b00, 1'b1, 2'b10, ne, alu, 2'b00};
    endfunction
    function automatic logic [13:0] iwbx(input logic ne);
        return {2'b00, 2'b00, 1'b0, 2'b00, ne, 4'b0000, 2'b00};
    endfunction

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic m,
                       input logic [3:0] st, input logic [6:0] s, input logic [13:0] x);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.mr = m; v.st = st; v.s = s; v.x = x;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rfun[6], badf[4], badop[5], imms[4];
        logic [5:0] iop, ifn;
        int path[$];
        int cls, idx, st, cyc;
        logic e_rw, e_pw, e_ill, e_mr, e_mw;
        rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        badf = '{6'b000001, 6'b000000, 6'b100001, 6'b111111};
        badop = '{6'b111111, 6'b000001, 6'b001111, 6'b100000, 6'b000110};
        imms = '{ADDI, ANDI, ORI, SLTI};
        // lw with one MEMRD wait; mem_ready ignored in DECODE/MEMADR
        add(LW, 0, 0, 1, 0, S_F1, X_FETCH); add(LW, 0, 0, 0, 1, S_NO, X_DEC); add(LW, 0, 0, 0, 2, S_NO, X_MADR);
        add(LW, 0, 0, 0, 3, S_RD, X_NO); add(LW, 0, 0, 1, 3, S_RD, X_NO); add(LW, 0, 0, 0, 4, S_WB, X_MEMWB);
        // sw with one MEMWR wait
        add(SW, 0, 0, 1, 0, S_F1, X_FETCH); add(SW, 0, 0, 1, 1, S_NO, X_DEC); add(SW, 0, 0, 1, 2, S_NO, X_MADR);
        add(SW, 0, 0, 0, 5, S_WR, X_NO); add(SW, 0, 0, 1, 5, S_WR, X_NO);
        // add with three fetch wait cycles: 7 cycles total
        add(RT, 6'b100000, 0, 0, 0, S_F0, X_FETCH); add(RT, 6'b100000, 0, 0, 0, S_F0, X_FETCH);
        add(RT, 6'b100000, 0, 0, 0, S_F0, X_FETCH); add(RT, 6'b100000, 0, 1, 0, S_F1, X_FETCH);
        add(RT, 6'b100000, 0, 1, 1, S_NO, X_DEC); add(RT, 6'b100000, 0, 1, 6, S_NO, rexx(4'b0010));
        add(RT, 6'b100000, 0, 1, 7, S_WB, X_ALUWB);
        // nor
        add(RT, 6'b100111, 0, 1, 0, S_F1, X_FETCH); add(RT, 6'b100111, 0, 1, 1, S_NO, X_DEC);
        add(RT, 6'b100111, 0, 1, 6, S_NO, rexx(4'b1100)); add(RT, 6'b100111, 0, 1, 7, S_WB, X_ALUWB);
        // beq/bne, taken and not taken
        add(BEQ, 0, 1, 1, 0, S_F1, X_FETCH); add(BEQ, 0, 1, 1, 1, S_NO, X_DEC); add(BEQ, 0, 1, 1, 8, S_PW, X_BR);
        add(BEQ, 0, 0, 1, 0, S_F1, X_FETCH); add(BEQ, 0, 0, 1, 1, S_NO, X_DEC); add(BEQ, 0, 0, 1, 8, S_NO, X_BR);
        add(BNE, 0, 0, 1, 0, S_F1, X_FETCH); add(BNE, 0, 0, 1, 1, S_NO, X_DEC); add(BNE, 0, 0, 1, 8, S_PW, X_BR);
        add(BNE, 0, 1, 1, 0, S_F1, X_FETCH); add(BNE, 0, 1, 1, 1, S_NO, X_DEC); add(BNE, 0, 1, 1, 8, S_NO, X_BR);
        // jal, j, jr
        add(JAL, 0, 0, 1, 0, S_F1, X_FETCH); add(JAL, 0, 0, 1, 1, S_NO, X_DEC); add(JAL, 0, 0, 1, 11, S_JAL, X_JAL);
        add(J, 0, 0, 1, 0, S_F1, X_FETCH); add(J, 0, 0, 1, 1, S_NO, X_DEC); add(J, 0, 0, 1, 11, S_PW, X_J);
        add(RT, 6'b001000, 0, 1, 0, S_F1, X_FETCH); add(RT, 6'b001000, 0, 1, 1, S_NO, X_DEC);
        add(RT, 6'b001000, 0, 1, 12, S_PW, X_JR);
        // andi (zero-extend held into IWB), slti
        add(ANDI, 0, 0, 1, 0, S_F1, X_FETCH); add(ANDI, 0, 0, 1, 1, S_NO, X_DEC);
        add(ANDI, 0, 0, 1, 9, S_NO, iexx(1, 4'b0000)); add(ANDI, 0, 0, 1, 10, S_WB, iwbx(1));
        add(SLTI, 0, 0, 1, 0, S_F1, X_FETCH); add(SLTI, 0, 0, 1, 1, S_NO, X_DEC);
        add(SLTI, 0, 0, 1, 9, S_NO, iexx(0, 4'b0111)); add(SLTI, 0, 0, 1, 10, S_WB, iwbx(0));
        // illegal op, then illegal funct, then back in FETCH
        add(6'b111111, 0, 0, 1, 0, S_F1, X_FETCH); add(6'b111111, 0, 0, 1, 1, S_ILL, X_DEC);
        add(RT, 6'b000001, 0, 1, 0, S_F1, X_FETCH); add(RT, 6'b000001, 0, 1, 1, S_NO, X_DEC);
        add(RT, 6'b000001, 0, 1, 6, S_ILL, rexx(4'b0000)); add(RT, 6'b000001, 0, 0, 0, S_F0, X_FETCH);

        @(negedge clk);
        #1 chk("reset_hold", all_act, 26'b0);
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero; mem_ready = tbl[i].mr;
            #1 chk($sformatf("vec%0d", i), all_act, {1'b0, tbl[i].st, tbl[i].s, tbl[i].x});
        end

        // random instructions against a path model
        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 8);
            iop = RT; ifn = 6'b000000;
            case (cls)
                0: begin iop = LW; path = {0, 1, 2, 3, 4}; end
                1: begin iop = SW; path = {0, 1, 2, 5}; end
                2: begin ifn = rfun[$urandom_range(0, 5)]; path = {0, 1, 6, 7}; end
                3: begin ifn = badf[$urandom_range(0, 3)]; path = {0, 1, 6}; end
                4: begin iop = $urandom_range(0, 1) ? BEQ : BNE; path = {0, 1, 8}; end
                5: begin iop = imms[$urandom_range(0, 3)]; path = {0, 1, 9, 10}; end
                6: begin iop = $urandom_range(0, 1) ? J : JAL; path = {0, 1, 11}; end
                7: begin ifn = 6'b001000; path = {0, 1, 12}; end
                default: begin iop = badop[$urandom_range(0, 4)]; path = {0, 1}; end
            endcase
            idx = 0; cyc = 0;
            while (idx < path.size()) begin
                @(negedge clk);
                op = iop; funct = ifn; zero = 1'($urandom_range(0, 1)); mem_ready = $urandom_range(0, 3) != 0;
                #1;
                st = path[idx];
                e_rw = st == 4 || st == 7 || st == 10 || (st == 11 && iop == JAL);
                e_pw = (st == 0 && mem_ready) || st == 11 || st == 12 || (st == 8 && ((iop == BEQ) == zero));
                e_ill = (st == 1 && cls == 8) || (st == 6 && cls == 3);
                e_mr = st == 0 || st == 3;
                e_mw = st == 5;
                chk($sformatf("rand%0d_c%0d", n, cyc), {bus_error, state_out, reg_write, pc_write, illegal_op, mem_read, mem_write},
                    {1'b0, 4'(st), e_rw, e_pw, e_ill, e_mr, e_mw});
                if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) idx++;
                cyc++;
                if (cyc > 200) begin
                    chk("rand_bound", 32'(cyc), 32'd200);
                    idx = path.size();
                end
            end
        end

        // asynchronous reset in the middle of a stalled load
        @(negedge clk); op = LW; funct = 0; zero = 0; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_reset_memrd", {state_out, s_act}, {4'd3, S_RD});
        #2 reset = 1'b1;
        #1 chk("reset_async", all_act, 26'b0);
        @(negedge clk); reset = 1'b0;
        #1 chk("after_reset", all_act, {1'b0, 4'd0, S_F0, X_FETCH});

`ifdef MIPS_MC_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1 chk($sformatf("to_wait%0d", k), {bus_error, state_out}, 5'b0_0000);
        end
        @(negedge clk);
        #1 chk("to_error", all_act, {1'b1, 4'd15, S_NO, X_NO});
        mem_ready = 1'b1;
        @(negedge clk);
        #1 chk("error_sticky", all_act, {1'b1, 4'd15, S_NO, X_NO});
        reset = 1'b1;
        #1 chk("error_reset", all_act, 26'b0);
        @(negedge clk); reset = 1'b0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle control unit for the next-generation MIPS core.
- Replaces single-cycle decode with a Moore FSM that shares one ALU and one memory port across instruction phases.
- Adds a memory wait-state handshake (mem_ready), JAL/JR support and explicit branch resolution.
- Sits between instruction/data memory and the multicycle datapath; drives every datapath strobe and mux select.

Parameters:
- ALU_CTRL_W, 4, width of alu_control.
- TIMEOUT_CYCLES, 16, maximum wait for mem_ready before bus error (used only with MIPS_MC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  instruction[31:26] from instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- reg_dst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = regA.
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- no_ext  out  1  1 = zero-extend immediate, 0 = sign-extend.
- alu_control  out  ALU_CTRL_W  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = regA.
- pc_write  out  1  PC load, with branch already resolved.
- illegal_op  out  1  one-cycle pulse on an unsupported op or funct.
- bus_error  out  1  sticky memory timeout flag.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Reset: asynchronous set to state FETCH (0). All strobes, illegal_op and bus_error are 0 while reset is high. Selects are 0.
- Outputs are Moore-decoded from the state. Only pc_write in BRANCH also depends on zero.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, ALUWB 7, BRANCH 8, IEX 9, IWB 10, JUMP 11, JR 12, ERROR 15.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. ir_write and pc_write equal mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target precompute). Next state by op:
  - 100011 / 101011 → MEMADR
  - 000000 → REX, or JR if funct=001000
  - 000100 / 000101 → BRANCH
  - 001000 / 001100 / 001101 / 001010 → IEX
  - 000010 / 000011 → JUMP
  - anything else → illegal_op=1, then FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- REX: alu_src_a=1, alu_src_b=00. funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR. Any other funct → illegal_op=1, then FETCH; otherwise ALUWB.
- ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write = (op==000100 & zero) | (op==000101 & ~zero). Then FETCH.
- IEX: alu_src_a=1, alu_src_b=10, ALU op ADD/AND/OR/SLT for addi/andi/ori/slti. no_ext=1 for andi/ori. Then IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00. no_ext is held. Then FETCH.
- JUMP: pc_src=10, pc_write=1. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Then FETCH.
- JR: pc_src=11, pc_write=1, then FETCH.
- Cycle counts with zero wait states:
  - lw 5; sw, R-type, immediate ops 4; branch, j, jal, jr 3.
  - Each wait cycle with mem_ready low adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Unused state encodings recover to FETCH on the next clock.

Optional Feature:
- MIPS_MC_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready is 0.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, go to ERROR.
  - ERROR: all strobes 0, bus_error=1. Only reset exits ERROR.
- Not defined: no counter, waits are unbounded, bus_error tied to 0, ERROR unreachable.

Test Plan:
- Reset pulse mid-MEMRD → state_out=0 immediately, all strobes 0. After release: FETCH with mem_read=1.
- lw (op=100011), mem_ready always 1 → states 0,1,2,3,4. reg_write=1 only in state 4 with mem_to_reg=01.
- beq with zero=1, then beq with zero=0 → pc_write=1 / 0 in BRANCH, pc_src=01. bne (000101) gives the inverse.
- jal (000011) → 3 cycles. JUMP asserts reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10.
- Fetch with mem_ready low for 3 cycles → FETCH held 4 cycles, ir_write=1 only in the 4th. Total add latency = 7 cycles.
- op=111111, then op=000000 with funct=000001 → illegal_op pulses one cycle, then back to FETCH. With MIPS_MC_TIMEOUT_EN and mem_ready stuck 0 for 16 cycles → state 15, bus_error=1 until reset.
